instruction_word_assembler: RTL and testbench

- Packs decoded instruction fields (opcode, Ra, Rb, Rc, constant) into 32-bit IR words in the CPU's instruction format.
- Writes each packed word sequentially into instruction memory through a handshaked write port.
- Performs the inverse of the IR field select/decode path. Sits between the test/boot loader and the memory write port.
- Checks that each constant fits its signed field and times out stalled memory writes.

---
 rtl/ir_format_pkg.sv | 38 +++
 rtl/instruction_word_assembler_if.sv | 33 +++
 rtl/instruction_word_assembler_packer.sv | 35 +++
 rtl/instruction_word_assembler.sv | 136 +++++++++++++
 tb/tb_instruction_word_assembler.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/ir_format_pkg.sv
// Shared IR instruction-format definitions used by the encode (assembler) and decode (field select) paths.
package ir_format_pkg;

  localparam int IR_W    = 32;
  localparam int OP_W    = 5;
  localparam int REG_W   = 4;
  localparam int CONST_W = 19;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;
  localparam int C_MSB  = 18;
  localparam int C_LSB  = 0;

  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_B = 2'd2,
    FMT_J = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WRITE
  } state_e;

  // A 32-bit constant fits the signed 19-bit field when bits 31..18 are all copies of the sign.
  function automatic logic imm_fits(input logic [IR_W-1:0] imm);
    return (&imm[IR_W-1:CONST_W-1]) | ~(|imm[IR_W-1:CONST_W-1]);
  endfunction

endpackage

// File: rtl/instruction_word_assembler_if.sv
// Field-set handshake from the loader plus the instruction-memory write port.
interface instruction_word_assembler_if #(
  parameter int ADDR_W = 9
);
  import ir_format_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  fmt_e                 fmt;
  logic [OP_W-1:0]      opcode;
  logic [REG_W-1:0]     ra;
  logic [REG_W-1:0]     rb;
  logic [REG_W-1:0]     rc;
  logic [IR_W-1:0]      imm;
  logic                 load_addr;
  logic [ADDR_W-1:0]    start_addr;
  logic [ADDR_W-1:0]    mem_addr;
  logic [IR_W-1:0]      mem_data;
  logic                 mem_wr;
  logic                 mem_ack;

  // slave: the assembler; master: the loader and memory around it.
  modport slave (
    input  in_valid, fmt, opcode, ra, rb, rc, imm, load_addr, start_addr, mem_ack,
    output in_ready, mem_addr, mem_data, mem_wr
  );

  modport master (
    output in_valid, fmt, opcode, ra, rb, rc, imm, load_addr, start_addr, mem_ack,
    input  in_ready, mem_addr, mem_data, mem_wr
  );

endinterface

// File: rtl/instruction_word_assembler_packer.sv
// ir_field_packer: combinational encode of decoded fields into one IR word, with constant range check.
module ir_field_packer
  import ir_format_pkg::*;
(
  input  fmt_e              i_fmt,
  input  logic [OP_W-1:0]   i_opcode,
  input  logic [REG_W-1:0]  i_ra,
  input  logic [REG_W-1:0]  i_rb,
  input  logic [REG_W-1:0]  i_rc,
  input  logic [IR_W-1:0]   i_imm,
  output logic [IR_W-1:0]   o_word,
  output logic              o_range_ok
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    o_word                = '0;
    o_range_ok            = 1'b1;
    o_word[OP_MSB:OP_LSB] = i_opcode;
    o_word[RA_MSB:RA_LSB] = i_ra;
    case (i_fmt)
      FMT_R: begin
        o_word[RB_MSB:RB_LSB] = i_rb;
        o_word[RC_MSB:RC_LSB] = i_rc;
      end
      FMT_I, FMT_B: begin
        o_word[RB_MSB:RB_LSB] = i_rb;
        o_word[C_MSB:C_LSB]   = i_imm[CONST_W-1:0];
        o_range_ok            = imm_fits(i_imm);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instruction_word_assembler.sv
// Accepts decoded field sets, packs them into IR words and writes them sequentially to instruction memory.
module instruction_word_assembler
  import ir_format_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic                        clock,
  input  logic                        clear,
  instruction_word_assembler_if.slave bus,
  output logic [9:0]                  words_written,
  output logic                        err,
  output logic                        busy
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  state_e             r_state;
  fmt_e               r_fmt;
  logic [OP_W-1:0]    r_opcode;
  logic [REG_W-1:0]   r_ra;
  logic [REG_W-1:0]   r_rb;
  logic [REG_W-1:0]   r_rc;
  logic [IR_W-1:0]    r_imm;
  logic [ADDR_W-1:0]  r_ptr;
  logic [TMR_W-1:0]   r_timer;
  logic               r_in_ready;
  logic               r_mem_wr;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [IR_W-1:0]    r_mem_data;
  logic [9:0]         r_count;
  logic               r_err;
  logic               r_busy;

  logic [IR_W-1:0]    w_word;
  logic               w_range_ok;

  ir_field_packer u_packer (
    .i_fmt      (r_fmt),
    .i_opcode   (r_opcode),
    .i_ra       (r_ra),
    .i_rb       (r_rb),
    .i_rc       (r_rc),
    .i_imm      (r_imm),
    .o_word     (w_word),
    .o_range_ok (w_range_ok)
  );

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state    <= ST_IDLE;
      r_fmt      <= FMT_R;
      r_opcode   <= '0;
      r_ra       <= '0;
      r_rb       <= '0;
      r_rc       <= '0;
      r_imm      <= '0;
      r_ptr      <= '0;
      r_timer    <= '0;
      r_in_ready <= 1'b1;
      r_mem_wr   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_count    <= '0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.load_addr) r_ptr <= bus.start_addr;
          if (bus.in_valid) begin
            r_fmt      <= bus.fmt;
            r_opcode   <= bus.opcode;
            r_ra       <= bus.ra;
            r_rb       <= bus.rb;
            r_rc       <= bus.rc;
            r_imm      <= bus.imm;
            r_state    <= ST_CHECK;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_CHECK: begin
          if (w_range_ok) begin
            r_mem_data <= w_word;
            r_mem_addr <= r_ptr;
            r_mem_wr   <= 1'b1;
            r_timer    <= '0;
            r_state    <= ST_WRITE;
          end else begin
            r_err      <= 1'b1;
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end
        end
        ST_WRITE: begin
          // An ack in the final allowed cycle wins over the timeout.
          if (bus.mem_ack) begin
            r_ptr      <= r_ptr + ADDR_W'(1);
            if (r_count != 10'd1023) r_count <= r_count + 10'd1;
            r_mem_wr   <= 1'b0;
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
            r_err      <= 1'b1;
            r_mem_wr   <= 1'b0;
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_mem_wr   <= 1'b0;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.mem_wr    = r_mem_wr;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_data  = r_mem_data;
  assign words_written = r_count;
  assign err           = r_err;
  assign busy          = r_busy;

endmodule

// File: tb/tb_instruction_word_assembler.sv
// Directed self-checking bench for instruction_word_assembler with hand-computed IR words.
module tb_instruction_word_assembler;
  import ir_format_pkg::*;

  logic       clock;
  logic       clear;
  logic [9:0] words_written;
  logic       err;
  logic       busy;
  int         n_checks;
  int         n_fail;

  instruction_word_assembler_if #(.ADDR_W(9)) bus ();

  instruction_word_assembler #(.ADDR_W(9), .TIMEOUT(15)) dut (
    .clock         (clock),
    .clear         (clear),
    .bus           (bus.slave),
    .words_written (words_written),
    .err           (err),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents one field set while in_ready is high; returns in the CHECK cycle.
  task automatic send(input fmt_e f, input logic [4:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [31:0] imm);
    bus.fmt      = f;
    bus.opcode   = op;
    bus.ra       = a;
    bus.rb       = b;
    bus.rc       = c;
    bus.imm      = imm;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    tick();
    tick();
    clear = 1'b0;
    tick();
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    n_checks++; if (bus.mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr: got %b expected 0", bus.mem_wr); end
    n_checks++; if (bus.mem_addr !== 9'd0) begin n_fail++; $display("FAIL reset_mem_addr: got %0d expected 0", bus.mem_addr); end
    n_checks++; if (bus.mem_data !== 32'h0) begin n_fail++; $display("FAIL reset_mem_data: got %h expected 0", bus.mem_data); end
    n_checks++; if (words_written !== 10'd0) begin n_fail++; $display("FAIL reset_words: got %0d expected 0", words_written); end
    n_checks++; if (err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_err_busy: got %b%b expected 00", err, busy); end
  endtask

  task automatic test_r_format();
    send(FMT_R, 5'd3, 4'd1, 4'd2, 4'd3, 32'h0);
    n_checks++; if (busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.mem_wr !== 1'b0) begin
      n_fail++; $display("FAIL r_check_cycle: got busy=%b ready=%b wr=%b expected 1 0 0", busy, bus.in_ready, bus.mem_wr); end
    tick();
    n_checks++; if (bus.mem_wr !== 1'b1) begin n_fail++; $display("FAIL r_mem_wr: got %b expected 1", bus.mem_wr); end
    n_checks++; if (bus.mem_data !== 32'h18918000) begin n_fail++; $display("FAIL r_data: got %h expected 18918000", bus.mem_data); end
    n_checks++; if (bus.mem_addr !== 9'd0) begin n_fail++; $display("FAIL r_addr: got %0d expected 0", bus.mem_addr); end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b1 || bus.mem_wr !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL r_done: got ready=%b wr=%b busy=%b expected 1 0 0", bus.in_ready, bus.mem_wr, busy); end
    n_checks++; if (words_written !== 10'd1) begin n_fail++; $display("FAIL r_words: got %0d expected 1", words_written); end
  endtask

  task automatic test_i_format();
    send(FMT_I, 5'd12, 4'd2, 4'd2, 4'd0, 32'hFFFFFFFB);
    tick();
    n_checks++; if (bus.mem_data !== 32'h6117FFFB) begin n_fail++; $display("FAIL i_data: got %h expected 6117fffb", bus.mem_data); end
    n_checks++; if (bus.mem_addr !== 9'd1) begin n_fail++; $display("FAIL i_addr: got %0d expected 1", bus.mem_addr); end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    n_checks++; if (words_written !== 10'd2) begin n_fail++; $display("FAIL i_words: got %0d expected 2", words_written); end
    // 0x00040000 sets bit 18 only: one past the largest positive constant.
    send(FMT_I, 5'd12, 4'd2, 4'd2, 4'd0, 32'h00040000);
    n_checks++; if (err !== 1'b0 || bus.mem_wr !== 1'b0) begin n_fail++; $display("FAIL i_range_n1: got err=%b wr=%b expected 0 0", err, bus.mem_wr); end
    tick();
    n_checks++; if (err !== 1'b1 || bus.in_ready !== 1'b1 || bus.mem_wr !== 1'b0) begin
      n_fail++; $display("FAIL i_range_err: got err=%b ready=%b wr=%b expected 1 1 0", err, bus.in_ready, bus.mem_wr); end
    tick();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL i_range_pulse: got %b expected 0", err); end
    n_checks++; if (words_written !== 10'd2) begin n_fail++; $display("FAIL i_range_words: got %0d expected 2", words_written); end
  endtask

  task automatic test_b_format();
    send(FMT_B, 5'd5, 4'd3, 4'd9, 4'd0, 32'h0003FFFF);
    tick();
    n_checks++; if (bus.mem_data !== 32'h29CBFFFF) begin n_fail++; $display("FAIL b_data_max: got %h expected 29cbffff", bus.mem_data); end
    n_checks++; if (bus.mem_addr !== 9'd2) begin n_fail++; $display("FAIL b_addr: got %0d expected 2", bus.mem_addr); end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    // One below the most negative constant.
    send(FMT_B, 5'd5, 4'd3, 4'd9, 4'd0, 32'hFFFBFFFF);
    tick();
    n_checks++; if (err !== 1'b1 || bus.mem_wr !== 1'b0) begin n_fail++; $display("FAIL b_range_err: got err=%b wr=%b expected 1 0", err, bus.mem_wr); end
    tick();
    n_checks++; if (words_written !== 10'd3) begin n_fail++; $display("FAIL b_words: got %0d expected 3", words_written); end
  endtask

  task automatic test_j_format();
    send(FMT_J, 5'd20, 4'd7, 4'd5, 4'd6, 32'hFFFFFFFF);
    tick();
    n_checks++; if (err !== 1'b0 || bus.mem_wr !== 1'b1) begin n_fail++; $display("FAIL j_no_err: got err=%b wr=%b expected 0 1", err, bus.mem_wr); end
    n_checks++; if (bus.mem_data !== 32'hA3800000) begin n_fail++; $display("FAIL j_data: got %h expected a3800000", bus.mem_data); end
    n_checks++; if (bus.mem_addr !== 9'd3) begin n_fail++; $display("FAIL j_addr: got %0d expected 3", bus.mem_addr); end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    n_checks++; if (words_written !== 10'd4) begin n_fail++; $display("FAIL j_words: got %0d expected 4", words_written); end
  endtask

  task automatic test_timeout();
    int cnt;
    send(FMT_R, 5'd1, 4'd0, 4'd0, 4'd0, 32'h0);
    tick();
    cnt = 0;
    for (int i = 0; i < 20 && bus.mem_wr === 1'b1; i++) begin
      cnt++;
      tick();
    end
    n_checks++; if (cnt != 15) begin n_fail++; $display("FAIL to_wr_cycles: got %0d expected 15", cnt); end
    n_checks++; if (err !== 1'b1 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL to_err: got err=%b ready=%b expected 1 1", err, bus.in_ready); end
    n_checks++; if (words_written !== 10'd4) begin n_fail++; $display("FAIL to_words: got %0d expected 4", words_written); end
    tick();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_pulse: got %b expected 0", err); end
    // Retry, acking in the 15th write cycle.
    send(FMT_J, 5'd2, 4'd1, 4'd0, 4'd0, 32'h0);
    tick();
    for (int i = 0; i < 14; i++) tick();
    n_checks++; if (bus.mem_wr !== 1'b1 || bus.mem_addr !== 9'd4) begin
      n_fail++; $display("FAIL to_retry_c15: got wr=%b addr=%0d expected 1 4", bus.mem_wr, bus.mem_addr); end
    n_checks++; if (bus.mem_data !== 32'h10800000) begin n_fail++; $display("FAIL to_retry_data: got %h expected 10800000", bus.mem_data); end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    n_checks++; if (err !== 1'b0 || bus.mem_wr !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL to_retry_done: got err=%b wr=%b ready=%b expected 0 0 1", err, bus.mem_wr, bus.in_ready); end
    n_checks++; if (words_written !== 10'd5) begin n_fail++; $display("FAIL to_retry_words: got %0d expected 5", words_written); end
  endtask

  task automatic test_ack_idle();
    bus.mem_ack = 1'b1;
    tick();
    tick();
    bus.mem_ack = 1'b0;
    n_checks++; if (words_written !== 10'd5 || bus.mem_wr !== 1'b0) begin
      n_fail++; $display("FAIL idle_ack: got words=%0d wr=%b expected 5 0", words_written, bus.mem_wr); end
  endtask

  task automatic test_pointer_wrap();
    bus.load_addr  = 1'b1;
    bus.start_addr = 9'd511;
    send(FMT_R, 5'd31, 4'd15, 4'd15, 4'd15, 32'h0);
    bus.load_addr = 1'b0;
    tick();
    n_checks++; if (bus.mem_addr !== 9'd511) begin n_fail++; $display("FAIL wrap_addr_511: got %0d expected 511", bus.mem_addr); end
    n_checks++; if (bus.mem_data !== 32'hFFFF8000) begin n_fail++; $display("FAIL wrap_data: got %h expected ffff8000", bus.mem_data); end
    bus.load_addr  = 1'b1;
    bus.start_addr = 9'd100;
    bus.mem_ack    = 1'b1;
    tick();
    bus.mem_ack    = 1'b0;
    bus.load_addr  = 1'b0;
    // Back-to-back: next field set is presented in the first IDLE cycle.
    send(FMT_J, 5'd0, 4'd0, 4'd0, 4'd0, 32'h0);
    tick();
    n_checks++; if (bus.mem_addr !== 9'd0) begin n_fail++; $display("FAIL wrap_addr_0: got %0d expected 0", bus.mem_addr); end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    n_checks++; if (words_written !== 10'd7) begin n_fail++; $display("FAIL wrap_words: got %0d expected 7", words_written); end
  endtask

  task automatic test_clear_mid_write();
    send(FMT_R, 5'd3, 4'd1, 4'd2, 4'd3, 32'h0);
    tick();
    n_checks++; if (bus.mem_wr !== 1'b1 || bus.mem_addr !== 9'd1) begin
      n_fail++; $display("FAIL clr_pre: got wr=%b addr=%0d expected 1 1", bus.mem_wr, bus.mem_addr); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++; if (bus.mem_wr !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL clr_wr_busy: got wr=%b busy=%b expected 0 0", bus.mem_wr, busy); end
    n_checks++; if (words_written !== 10'd0) begin n_fail++; $display("FAIL clr_words: got %0d expected 0", words_written); end
    n_checks++; if (bus.mem_addr !== 9'd0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL clr_addr_ready: got addr=%0d ready=%b expected 0 1", bus.mem_addr, bus.in_ready); end
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    clear          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.fmt        = FMT_R;
    bus.opcode     = '0;
    bus.ra         = '0;
    bus.rb         = '0;
    bus.rc         = '0;
    bus.imm        = '0;
    bus.load_addr  = 1'b0;
    bus.start_addr = '0;
    bus.mem_ack    = 1'b0;
    test_reset();
    test_r_format();
    test_i_format();
    test_b_format();
    test_j_format();
    test_timeout();
    test_ack_idle();
    test_pointer_wrap();
    test_clear_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
